// File: rtl/sd_sched_pkg.sv
// Shared definitions for the mirrored-fork credit scheduler: FSM encoding
// and the statistics counter width.
package sd_sched_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WAIT  = 2'd1,
      VALID = 2'd2
   } sched_state_t;

   localparam int STATS_W = 16;

endpackage

// File: rtl/sd_mirror_sched_if.sv
// Item channel in (c_*) and scheduled channel out (p_*) of sd_mirror_sched.
// Handshake: a beat moves on a rising clk edge where srdy & drdy are both high;
// a source holding srdy keeps its data stable until the beat is taken.
interface sd_mirror_sched_if #(
   parameter int mirror = 2,
   parameter int width  = 128,
   parameter int tag_w  = 3
);
   logic              c_srdy;
   logic              c_drdy;
   logic [width-1:0]  c_data;
   logic [tag_w-1:0]  c_tag;
   logic              p_srdy;
   logic              p_drdy;
   logic [width-1:0]  p_data;
   logic [mirror-1:0] p_dst_vld;

   modport master (
      output c_srdy, c_data, c_tag, p_drdy,
      input  c_drdy, p_srdy, p_data, p_dst_vld
   );

   modport slave (
      input  c_srdy, c_data, c_tag, p_drdy,
      output c_drdy, p_srdy, p_data, p_dst_vld
   );
endinterface

// File: rtl/sd_credit_cnt.sv
// Per-destination credit counter: decrement on transfer, increment on return,
// saturating at max_credit with a sticky overflow error.
module sd_credit_cnt #(
   parameter int credit_w   = 4,
   parameter int max_credit = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                dec,
   input  logic                ret,
   output logic [credit_w-1:0] credit,
   output logic                nonzero,
   output logic                err
);
   localparam logic [credit_w-1:0] MAX = credit_w'(max_credit);

   logic [credit_w-1:0] nxt;
   logic                sat;

   always_comb begin
      nxt = credit;
      sat = 1'b0;
      if (dec && !ret) begin
         nxt = credit - 1'b1;
      end else if (ret && !dec) begin
         if (credit == MAX) sat = 1'b1;
         else               nxt = credit + 1'b1;
      end
   end

   // Reflects the post-edge value so the scheduler can commit in the same cycle
   assign nonzero = (nxt != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         credit <= MAX;
         err    <= 1'b0;
      end else begin
         credit <= nxt;
         if (sat) err <= 1'b1;
      end
   end

   no_dec_at_zero: assert property (@(posedge clk) disable iff (!reset_n)
      !(dec && credit == '0));

endmodule

// File: rtl/sd_mirror_sched.sv
// Credit-based destination scheduler feeding a mirrored fork.
// Optional statistics counters: define SD_MIRROR_SCHED_STATS_EN.
module sd_mirror_sched
   import sd_sched_pkg::*;
#(
   parameter int mirror     = 2,
   parameter int width      = 128,
   parameter int tag_w      = 3,
   parameter int credit_w   = 4,
   parameter int max_credit = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   sd_mirror_sched_if.slave    bus,
   input  logic                cfg_wr,
   input  logic [tag_w-1:0]    cfg_addr,
   input  logic [mirror-1:0]   cfg_mask,
   input  logic [mirror-1:0]   crd_ret,
   output logic [mirror-1:0]   crd_err,
`ifdef SD_MIRROR_SCHED_STATS_EN
   input  logic                stats_clr,
   output logic [STATS_W-1:0]  drop_cnt,
   output logic [STATS_W-1:0]  xfer_cnt,
`endif
   output sched_state_t        fsm_state
);
   localparam int DEPTH = 1 << tag_w;

   sched_state_t        state, state_nxt;
   logic [mirror-1:0]   mask_tab [DEPTH];
   logic [mirror-1:0]   rd_mask;
   logic [mirror-1:0]   dec;
   logic [mirror-1:0]   nonzero;
   logic [credit_w-1:0] credit [mirror];
   logic                load, drop, xfer, load_ok, held_ok;

   // Combinational read returns the pre-write entry when cfg_wr hits the same tag
   assign rd_mask    = mask_tab[bus.c_tag];
   assign bus.c_drdy = (state == EMPTY) | ((state == VALID) & bus.p_drdy);
   assign bus.p_srdy = (state == VALID);
   assign fsm_state  = state;

   assign load    = bus.c_srdy & bus.c_drdy;
   assign drop    = load & (rd_mask == '0);
   assign xfer    = bus.p_srdy & bus.p_drdy;
   assign dec     = {mirror{xfer}} & bus.p_dst_vld;
   assign load_ok = &(nonzero | ~rd_mask);
   assign held_ok = &(nonzero | ~bus.p_dst_vld);

   for (genvar g = 0; g < mirror; g++) begin : g_crd
      sd_credit_cnt #(
         .credit_w   (credit_w),
         .max_credit (max_credit)
      ) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .dec     (dec[g]),
         .ret     (crd_ret[g]),
         .credit  (credit[g]),
         .nonzero (nonzero[g]),
         .err     (crd_err[g])
      );
   end

   always_comb begin
      state_nxt = state;
      if (load) begin
         if (drop)         state_nxt = EMPTY;
         else if (load_ok) state_nxt = VALID;
         else              state_nxt = WAIT;
      end else begin
         case (state)
            EMPTY:   state_nxt = EMPTY;
            WAIT:    if (held_ok) state_nxt = VALID;
            VALID:   if (bus.p_drdy) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= EMPTY;
         bus.p_data    <= '0;
         bus.p_dst_vld <= '0;
      end else begin
         state <= state_nxt;
         if (load && !drop) begin
            bus.p_data    <= bus.c_data;
            bus.p_dst_vld <= rd_mask;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mask_tab[i] <= '1;
      end else if (cfg_wr) begin
         mask_tab[cfg_addr] <= cfg_mask;
      end
   end

`ifdef SD_MIRROR_SCHED_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt <= '0;
         xfer_cnt <= '0;
      end else if (stats_clr) begin
         drop_cnt <= '0;
         xfer_cnt <= '0;
      end else begin
         if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         if (xfer && xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/sd_mirror_sched.md
Name: sd_mirror_sched

Overview:
Credit-based destination scheduler placed in front of a mirrored fork. Each input item carries a tag. A programmable tag table maps the tag to a destination mask. The block tracks per-destination credits and presents an item with its destination mask only when every selected destination has at least one credit. Its output drives a mirrored fork's c_srdy/c_drdy/c_data/c_dst_vld interface directly.

Parameters:
mirror, 2, number of downstream destinations
width, 128, data width
tag_w, 3, tag width; table depth is 2**tag_w
credit_w, 4, credit counter width
max_credit, 8, reset and maximum credit per destination (must be < 2**credit_w)

Ports:
clk  in  1  clock, posedge
reset_n  in  1  asynchronous, active-low reset
c_srdy  in  1  input item valid
c_drdy  out  1  input item accepted
c_data  in  width  input payload
c_tag  in  tag_w  table index for this item
cfg_wr  in  1  table write strobe
cfg_addr  in  tag_w  table write index
cfg_mask  in  mirror  destination mask to write
crd_ret  in  mirror  one-cycle credit-return pulse per destination
p_srdy  out  1  output valid (registered)
p_drdy  in  1  output accept
p_data  out  width  output payload (registered)
p_dst_vld  out  mirror  captured destination mask (registered)
crd_err  out  mirror  sticky, per destination; set on credit return while already at max_credit

Behaviour:
- Reset (reset_n low, async): state EMPTY; p_srdy=0; p_dst_vld=0; p_data=0; crd_err=0; all credits=max_credit; all table entries = all-ones (broadcast).
- State encoding: EMPTY, WAIT (item held, credits insufficient, p_srdy=0), VALID (p_srdy=1).
- c_drdy is combinational: c_drdy = (state==EMPTY) | (state==VALID & p_drdy). It is never asserted in WAIT.
- Load on c_srdy&c_drdy:
  - Read the mask from table[c_tag], using the pre-write value if cfg_wr hits the same entry in the same cycle.
  - mask==0: item is dropped and consumed; p_data is unchanged; next state EMPTY.
  - mask!=0: capture p_data<=c_data and p_dst_vld<=mask. Next state is VALID if every mask bit has nxt_credit>0, else WAIT.
- WAIT -> VALID: the first cycle in which all p_dst_vld bits have credit>0. p_srdy is asserted the following cycle.
- VALID with p_drdy and no load: go to EMPTY.
- Transfer (p_srdy&p_drdy): credit[i] is decremented for each set bit of p_dst_vld.
- Credit arithmetic: nxt_credit[i] = credit[i] - dec[i] + crd_ret[i].
  - Simultaneous dec and return: credit unchanged.
  - Return at max_credit with no dec: saturate at max_credit and set crd_err[i].
  - A decrement at 0 cannot occur by construction; assertion-check it.
- Latency: item accepted in cycle N appears with p_srdy=1 in cycle N+1 if credits are available. Throughput is 1 item/cycle while credits last.
- cfg_wr takes effect at the clock edge. It never affects an item already held.
- reset_n asserted mid-transfer: the held item is discarded and credits return to max_credit. Downstream must be reset together.

Optional Feature:
Macro SD_MIRROR_SCHED_STATS_EN.
- Defined:
  - Adds ports drop_cnt (out, 16) and xfer_cnt (out, 16), both saturating and reset to 0.
  - drop_cnt increments on each mask==0 consume.
  - xfer_cnt increments on each p_srdy&p_drdy.
  - Adds input stats_clr (1), a synchronous clear to 0 that takes priority over increment.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sd_sched_pkg holds:
  - the state encoding constants (EMPTY=2'd0, WAIT=2'd1, VALID=2'd2)
  - the stats counter width constant (16)
- Sub-module sd_credit_cnt, one per destination via generate:
  - inputs: dec, ret
  - outputs: credit, nonzero, err
  - handles saturation and the sticky error bit.

Test Plan:
- Reset, then push tag 0 (broadcast), p_drdy=1 -> p_srdy high the next cycle, p_dst_vld=2'b11, both credits 8->7.
- Program table[3]=2'b01, send 8 items with tag 3 and no crd_ret -> 8 transfers, then the 9th item sits in WAIT with c_drdy=0. Pulse crd_ret[0] -> p_srdy the next cycle.
- Program table[5]=0, send tag 5 -> item consumed, no p_srdy, state stays EMPTY; drop_cnt=1 with SD_MIRROR_SCHED_STATS_EN defined.
- Same cycle: crd_ret[1]=1 and a transfer with mask 2'b10 at credit 3 -> credit stays 3. crd_ret[0] at credit 8 -> credit stays 8, crd_err[0]=1 and stays set.
- cfg_wr to table[2]=2'b10 in the same cycle as a load of tag 2 (old value 2'b11) -> p_dst_vld=2'b11. The next tag-2 item gets 2'b10.
- Assert reset_n=0 while in VALID with p_drdy=0 -> p_srdy=0 immediately, credits=8, table back to all-ones.
